// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: major opcodes, ALU/writeback/branch codes,
// and small funct3 decode helpers used by the ID stage.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_fun_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  // alt is instr[30], already masked by the caller where it is not meaningful.
  function automatic alu_fun_e alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic br_type_e br_decode(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return BR_BEQ;
      3'd1:    return BR_BNE;
      3'd4:    return BR_BLT;
      3'd5:    return BR_BGE;
      3'd6:    return BR_BLTU;
      3'd7:    return BR_BGEU;
      default: return BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 2-read/1-write integer register file with x0 hardwired to zero.
// Optional same-cycle WB->read forwarding under `RF_WB_BYPASS_EN.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
  end

  // NOTE: the whole array is cleared by reset because software may read any
  // register before writing it; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
`ifdef RF_WB_BYPASS_EN
    if (we && waddr != '0 && waddr == raddr1) rdata1 = wdata;
    if (we && waddr != '0 && waddr == raddr2) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file, operand/control decode and load-use
// interlock. Define RF_WB_BYPASS_EN to forward same-cycle writeback data.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_pc4,
  input  logic            ex_flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_out,
  output logic            id_valid_out,
  output logic [31:0]     pc4_out,
  output logic [XLEN-1:0] operand1_out,
  output logic [XLEN-1:0] operand2_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [4:0]      rd_out,
  output logic [3:0]      alu_fun_out,
  output logic [1:0]      wb_sel_out,
  output logic            reg_we_out,
  output logic            mem_val_out,
  output logic            mem_rw_out,
  output logic [2:0]      mem_fn3_out,
  output logic [2:0]      br_type_out,
  output logic            illegal_out
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic [31:0] imm_i32, imm_s32, imm_u32, imm_j32;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j, pc_x;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];

  assign imm_i32 = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_u32 = {if_instr[31:12], 12'b0};
  assign imm_j32 = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
  assign imm_i   = XLEN'($signed(imm_i32));
  assign imm_s   = XLEN'($signed(imm_s32));
  assign imm_u   = XLEN'($signed(imm_u32));
  assign imm_j   = XLEN'($signed(imm_j32));
  assign pc_x    = XLEN'(if_pc);

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  logic [XLEN-1:0] op1, op2;
  alu_fun_e alu_fun;
  wb_sel_e  wb_sel;
  br_type_e br_type;
  logic dec_reg_we, dec_mem_val, mem_rw, use_rs1, use_rs2, is_load, illegal;

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    op1 = rs1_data;
    op2 = imm_i;
    alu_fun = ALU_ADD;
    wb_sel = WB_ALU;
    br_type = BR_NONE;
    dec_reg_we = 1'b0;
    dec_mem_val = 1'b0;
    mem_rw = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_load = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:    begin op1 = '0; op2 = imm_u; dec_reg_we = 1'b1; end
      OPC_AUIPC:  begin op1 = pc_x; op2 = imm_u; dec_reg_we = 1'b1; end
      OPC_JAL: begin
        op1 = pc_x; op2 = imm_j; wb_sel = WB_PC4; dec_reg_we = 1'b1; br_type = BR_JUMP;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; wb_sel = WB_PC4; dec_reg_we = 1'b1; br_type = BR_JUMP;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op2 = rs2_data; br_type = br_decode(funct3);
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; wb_sel = WB_MEM; dec_reg_we = 1'b1; dec_mem_val = 1'b1; is_load = 1'b1;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op2 = imm_s; dec_mem_val = 1'b1; mem_rw = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except for the right shifts.
        use_rs1 = 1'b1; dec_reg_we = 1'b1;
        alu_fun = alu_decode(funct3, if_instr[30] & (funct3 == 3'b101));
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op2 = rs2_data; dec_reg_we = 1'b1;
        alu_fun = alu_decode(funct3, if_instr[30]);
      end
      OPC_FENCE, OPC_SYSTEM: use_rs1 = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  logic       ld_pend_q, ld_pend_d;
  logic [4:0] ld_rd_q, ld_rd_d;
  logic       hz, id_valid, stall;

  assign hz = if_valid & ld_pend_q & (ld_rd_q != 5'd0) &
              ((use_rs1 & (rs1 == ld_rd_q)) | (use_rs2 & (rs2 == ld_rd_q)));

  // Flush beats the interlock; both drop the tracker so a held instruction
  // is re-presented next cycle without a second bubble.
  always_comb begin
    stall = 1'b0;
    id_valid = 1'b0;
    ld_pend_d = 1'b0;
    ld_rd_d = 5'd0;
    if (rst || ex_flush) begin
      stall = 1'b0;
    end else if (hz) begin
      stall = 1'b1;
    end else begin
      id_valid = if_valid & ~illegal;
      ld_pend_d = id_valid & is_load;
      ld_rd_d = rd;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_pend_q <= 1'b0;
      ld_rd_q <= 5'd0;
    end else begin
      ld_pend_q <= ld_pend_d;
      ld_rd_q <= ld_rd_d;
    end
  end

  assign stall_out    = stall;
  assign id_valid_out = id_valid;
  assign illegal_out  = ~rst & if_valid & illegal;
  assign reg_we_out   = id_valid & dec_reg_we;
  assign mem_val_out  = id_valid & dec_mem_val;
  assign rd_out       = reg_we_out ? rd : 5'd0;
  assign pc4_out      = if_pc4;
  assign operand1_out = op1;
  assign operand2_out = op2;
  assign rs2_data_out = rs2_data;
  assign alu_fun_out  = alu_fun;
  assign wb_sel_out   = wb_sel;
  assign mem_rw_out   = mem_rw;
  assign mem_fn3_out  = funct3;
  assign br_type_out  = br_type;

endmodule
